// File: rtl/param_cam_pkg.sv
// param_cam_pkg
//   Shared definitions for the parameterised CAM slice.
//   - Enable_/Disable_ : levels of the active-low enable inputs (we_, re_).
//   - cam_addr_width() : address width needed to index a given depth
//                        (never less than one bit).
package param_cam_pkg;

  localparam logic Enable_  = 1'b0;
  localparam logic Disable_ = 1'b1;

  function automatic int cam_addr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/cam_match_enc.sv
// cam_match_enc
//   Reduces one search port's per-entry hit vector to the CAM result.
//   Ports:
//     hits  in  [DEPTH]  one bit per entry, 1 = entry matched the key
//     match out          at least one hit
//     multi out          two or more hits
//     addr  out  [ADDR]  index of the lowest-numbered hit, 0 when none
module cam_match_enc #(
  parameter int DEPTH = 32,
  parameter int ADDR  = 5
) (
  input  logic [DEPTH-1:0] hits,
  output logic             match,
  output logic             multi,
  output logic [ADDR-1:0]  addr
);

  // Scan from the top entry down so the last hit seen is the lowest
  // index; a hit arriving when match is already set means a second hit.
  always_comb begin
    match = 1'b0;
    multi = 1'b0;
    addr  = '0;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      if (hits[e]) begin
        if (match) multi = 1'b1;
        match = 1'b1;
        addr  = ADDR'(e);
      end
    end
  end

endmodule

// File: rtl/param_cam.sv
// param_cam
//   Multi-port content-addressable memory: DEPTH words of DATA bits with a
//   valid flag each, WRITE masked address-directed write ports and READ
//   independent masked search ports.
//   Ports:
//     clk    in                 rising-edge clock
//     reset  in                 asynchronous active-high reset (clears all)
//     we_    in  [WRITE]        write enable per port, active-low
//     wm     in  [WRITE][DATA]  write mask, 1 keeps the stored bit
//     wd     in  [WRITE][DATA]  write data
//     waddr  in  [WRITE][ADDR]  write entry index (>= DEPTH is ignored)
//     re_    in  [READ]         search enable per port, active-low
//     rm     in  [READ][DATA]   search mask, 1 is don't-care
//     rd     in  [READ][DATA]   search key
//     match  out [READ]         any valid entry matched
//     multi  out [READ]         two or more valid entries matched
//     raddr  out [READ][ADDR]   lowest matching entry index, 0 when none
module param_cam
  import param_cam_pkg::*;
#(
  parameter int DATA  = 32,
  parameter int DEPTH = 32,
  parameter int WRITE = 4,
  parameter int READ  = 4,
  parameter int ADDR  = cam_addr_width(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WRITE-1:0]            we_,
  input  logic [WRITE-1:0][DATA-1:0]  wm,
  input  logic [WRITE-1:0][DATA-1:0]  wd,
  input  logic [WRITE-1:0][ADDR-1:0]  waddr,
  input  logic [READ-1:0]             re_,
  input  logic [READ-1:0][DATA-1:0]   rm,
  input  logic [READ-1:0][DATA-1:0]   rd,
  output logic [READ-1:0]             match,
  output logic [READ-1:0]             multi,
  output logic [READ-1:0][ADDR-1:0]   raddr
);

  logic [DATA-1:0]  data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] hits [READ];

  // Every port merges against the pre-edge contents, and later loop
  // iterations override earlier ones, so the highest-numbered port wins a
  // collision outright rather than having the masks combined.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      for (int e = 0; e < DEPTH; e++) data[e] <= '0;
    end else begin
      for (int w = 0; w < WRITE; w++) begin
        if (we_[w] == Enable_ && {1'b0, waddr[w]} < (ADDR + 1)'(DEPTH)) begin
          data[waddr[w]]  <= (data[waddr[w]] & wm[w]) | (wd[w] & ~wm[w]);
          valid[waddr[w]] <= 1'b1;
        end
      end
    end
  end

  // Hits look only at registered state, so a write in the same cycle is
  // not visible until after the edge.
  always_comb begin
    for (int r = 0; r < READ; r++) begin
      hits[r] = '0;
      for (int e = 0; e < DEPTH; e++) begin
        hits[r][e] = (re_[r] != Disable_) && valid[e] &&
                     (((data[e] ^ rd[r]) & ~rm[r]) == '0);
      end
    end
  end

  for (genvar r = 0; r < READ; r++) begin : g_enc
    cam_match_enc #(
      .DEPTH (DEPTH),
      .ADDR  (ADDR)
    ) u_enc (
      .hits  (hits[r]),
      .match (match[r]),
      .multi (multi[r]),
      .addr  (raddr[r])
    );
  end

endmodule

// File: tb/tb_param_cam.sv
// tb_param_cam
//   Directed bench for param_cam at default parameters (32x32, 4W/4R).
//   Expected results are hand-derived constants in each step.
module tb_param_cam;

  localparam int DATA  = 32;
  localparam int DEPTH = 32;
  localparam int WRITE = 4;
  localparam int READ  = 4;
  localparam int ADDR  = 5;

  logic                        clk;
  logic                        reset;
  logic [WRITE-1:0]            we_;
  logic [WRITE-1:0][DATA-1:0]  wm;
  logic [WRITE-1:0][DATA-1:0]  wd;
  logic [WRITE-1:0][ADDR-1:0]  waddr;
  logic [READ-1:0]             re_;
  logic [READ-1:0][DATA-1:0]   rm;
  logic [READ-1:0][DATA-1:0]   rd;
  logic [READ-1:0]             match;
  logic [READ-1:0]             multi;
  logic [READ-1:0][ADDR-1:0]   raddr;

  int checks_total  = 0;
  int checks_passed = 0;

  param_cam #(
    .DATA  (DATA),
    .DEPTH (DEPTH),
    .WRITE (WRITE),
    .READ  (READ)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we_   (we_),
    .wm    (wm),
    .wd    (wd),
    .waddr (waddr),
    .re_   (re_),
    .rm    (rm),
    .rd    (rd),
    .match (match),
    .multi (multi),
    .raddr (raddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int w, input logic [ADDR-1:0] a,
                               input logic [DATA-1:0] d, input logic [DATA-1:0] m);
    we_[w]   = 1'b0;
    waddr[w] = a;
    wd[w]    = d;
    wm[w]    = m;
  endtask

  task automatic set_search(input int r, input logic [DATA-1:0] key,
                            input logic [DATA-1:0] mask);
    re_[r] = 1'b0;
    rd[r]  = key;
    rm[r]  = mask;
  endtask

  task automatic checkOutput(input string tag, input int r, input logic exp_match,
                             input logic exp_multi, input logic [ADDR-1:0] exp_addr);
    checks_total++;
    assert (match[r] === exp_match) checks_passed++;
    else begin
      $display("[TB] FAIL %s port%0d match: got %b expected %b", tag, r, match[r], exp_match);
      $error("[TB] %s match", tag);
    end
    checks_total++;
    assert (multi[r] === exp_multi) checks_passed++;
    else begin
      $display("[TB] FAIL %s port%0d multi: got %b expected %b", tag, r, multi[r], exp_multi);
      $error("[TB] %s multi", tag);
    end
    checks_total++;
    assert (raddr[r] === exp_addr) checks_passed++;
    else begin
      $display("[TB] FAIL %s port%0d raddr: got %0d expected %0d", tag, r, raddr[r], exp_addr);
      $error("[TB] %s raddr", tag);
    end
  endtask

  initial begin
    reset = 1'b1;
    we_   = '1;
    wm    = '0;
    wd    = '0;
    waddr = '0;
    re_   = '1;
    rm    = '0;
    rd    = '0;

    // Reset state: key 0 would match zeroed data if anything were valid.
    for (int r = 0; r < READ; r++) set_search(r, 32'h0, 32'h0);
    #2;
    for (int r = 0; r < READ; r++) checkOutput("reset", r, 1'b0, 1'b0, 5'd0);
    tick();
    reset = 1'b0;
    #2;
    for (int r = 0; r < READ; r++) checkOutput("post_reset", r, 1'b0, 1'b0, 5'd0);

    // Four parallel writes; the same-cycle search must not see them.
    for (int i = 0; i < WRITE; i++) begin
      applyStimulus(i, ADDR'(2 * i), 32'h100 << i, 32'h0);
      set_search(i, 32'h100 << i, 32'h0);
    end
    #2;
    for (int r = 0; r < READ; r++) checkOutput("no_bypass", r, 1'b0, 1'b0, 5'd0);
    tick();
    we_ = '1;
    #2;
    for (int r = 0; r < READ; r++) checkOutput("par_write", r, 1'b1, 1'b0, ADDR'(2 * r));

    // Shifted keys: ports 0/1 find entries 4/6, ports 2/3 find nothing.
    for (int r = 0; r < READ; r++) set_search(r, 32'h100 << (r + 2), 32'h0);
    #2;
    checkOutput("shift", 0, 1'b1, 1'b0, 5'd4);
    checkOutput("shift", 1, 1'b1, 1'b0, 5'd6);
    checkOutput("shift", 2, 1'b0, 1'b0, 5'd0);
    checkOutput("shift", 3, 1'b0, 1'b0, 5'd0);

    // Duplicate 0xAA at entries 1 and 3.
    applyStimulus(0, 5'd1, 32'hAA, 32'h0);
    applyStimulus(1, 5'd3, 32'hAA, 32'h0);
    tick();
    we_ = '1;
    set_search(0, 32'hAA, 32'h0);
    set_search(1, 32'h0, 32'hFFFF_FFFF);
    set_search(2, 32'hAA, 32'h0);
    re_[2] = 1'b1;
    set_search(3, 32'h200, 32'h0);
    #2;
    checkOutput("dup_aa", 0, 1'b1, 1'b1, 5'd1);
    checkOutput("all_dc", 1, 1'b1, 1'b1, 5'd0);
    checkOutput("disabled", 2, 1'b0, 1'b0, 5'd0);
    checkOutput("single", 3, 1'b1, 1'b0, 5'd2);

    // Collision on entry 5: port 3 must win. Entry 7 gets a wide value.
    applyStimulus(0, 5'd5, 32'h11, 32'h0);
    applyStimulus(3, 5'd5, 32'h22, 32'h0);
    applyStimulus(1, 5'd7, 32'hDEAD_BE22, 32'h0);
    tick();
    we_ = '1;
    set_search(0, 32'h22, 32'h0);
    set_search(1, 32'h11, 32'h0);
    set_search(2, 32'hDEAD_BE22, 32'h0);
    set_search(3, 32'h22, 32'hFFFF_FF00);
    #2;
    checkOutput("collide_hi", 0, 1'b1, 1'b0, 5'd5);
    checkOutput("collide_lo", 1, 1'b0, 1'b0, 5'd0);
    checkOutput("wide", 2, 1'b1, 1'b0, 5'd7);
    checkOutput("low_byte22", 3, 1'b1, 1'b1, 5'd5);

    // Partial writes of the low byte; upper wd bits must be masked off.
    applyStimulus(1, 5'd5, 32'hFFFF_FF33, 32'hFFFF_FF00);
    applyStimulus(2, 5'd7, 32'h1234_5633, 32'hFFFF_FF00);
    tick();
    we_ = '1;
    set_search(0, 32'h33, 32'h0);
    set_search(1, 32'hDEAD_BE33, 32'h0);
    set_search(2, 32'h22, 32'h0);
    set_search(3, 32'h33, 32'hFFFF_FF00);
    #2;
    checkOutput("partial5", 0, 1'b1, 1'b0, 5'd5);
    checkOutput("partial7", 1, 1'b1, 1'b0, 5'd7);
    checkOutput("old_gone", 2, 1'b0, 1'b0, 5'd0);
    checkOutput("low_byte33", 3, 1'b1, 1'b1, 5'd5);

    // Asynchronous reset between edges clears everything at once.
    reset = 1'b1;
    #1;
    for (int r = 0; r < READ; r++) checkOutput("async_reset", r, 1'b0, 1'b0, 5'd0);
    tick();
    reset = 1'b0;
    set_search(0, 32'h0, 32'hFFFF_FFFF);
    #2;
    checkOutput("cleared", 0, 1'b0, 1'b0, 5'd0);
    checkOutput("cleared", 1, 1'b0, 1'b0, 5'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/param_cam.md
# param_cam

Parameterised multi-port content-addressable memory (module `param_cam`). Stores DEPTH words of DATA bits with a per-entry valid flag, accepts up to WRITE address-directed writes per cycle, and answers READ independent masked content searches each cycle with match, multi-hit and lowest matching address. Used as the associative lookup primitive (tag/ID matching) inside larger pipeline structures.

## Interface
- DATA, 32: stored word width.
- DEPTH, 32: number of entries.
- WRITE, 4: number of write ports.
- READ, 4: number of search ports.
- ADDR, $clog2(DEPTH): derived address width; not overridden.

One clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- we_  in  [WRITE]  per-port write enable, active-low.
- wm  in  [WRITE][DATA]  write mask; bit=1 keeps the stored bit, bit=0 writes it.
- wd  in  [WRITE][DATA]  write data.
- waddr  in  [WRITE][ADDR]  write entry index.
- re_  in  [READ]  per-port search enable, active-low.
- rm  in  [READ][DATA]  search mask; bit=1 is don't-care.
- rd  in  [READ][DATA]  search key.
- match  out  [READ]  at least one valid entry matches.
- multi  out  [READ]  two or more valid entries match.
- raddr  out  [READ][ADDR]  index of lowest matching entry.

## Operation
- Entry state: data[DEPTH][DATA], valid[DEPTH].
- Write port w active when we_[w]==0: data[waddr[w]] <= (data & wm[w]) | (wd[w] & ~wm[w]); valid[waddr[w]] <= 1.
- Several ports writing the same entry in one cycle: highest port index wins (masks not merged).
- waddr >= DEPTH (non-power-of-two DEPTH): write ignored.
- No delete/invalidate port; entries are invalidated only by reset.
- Search port r, entry e hits when re_[r]==0, valid[e]==1 and ((data[e] ^ rd[r]) & ~rm[r]) == 0.
- match[r] = OR of hits; multi[r] = popcount(hits) >= 2; raddr[r] = lowest-index hit.
- No hit or re_[r]==1: match=0, multi=0, raddr=0.
- All-ones rm matches every valid entry.

## Timing
- Reset (async assert, sync-safe deassert): all valid=0, all data=0; outputs therefore match=0, multi=0, raddr=0.
- Writes take effect at the rising clk edge; visible to searches from the next cycle.
- Searches are purely combinational over current stored state; no write-to-search bypass (a same-cycle write is not seen).
- Reset asserted mid-operation: contents lost immediately; outputs drop to 0 within the same cycle.
- Search ports are fully independent; any mix of simultaneous reads and writes is legal.

## Structure
- Shared package: ADDR derivation helper, `Disable_`/`Enable_` style polarity constants already in the codebase's standard defines (no new typedefs required).
- Sub-module `cam_match_enc`: DEPTH-bit hit vector -> match, multi, lowest-index ADDR encoding; one instance per search port.
- Top: storage array with write-port priority loop, per-port hit vector generation, READ encoder instances.

## Test plan
- Reset then search any key with rm=0 on all ports -> match=0, multi=0, raddr=0.
- Write port i: wd=0x100<<i, wm=0, waddr=2i (i=0..3) in one cycle; next cycle search port i rd=0x100<<i, rm=0 -> match=1, multi=0, raddr=2i.
- Search port i rd=0x100<<(i+2) -> ports 0,1: match=1, raddr=4 and 6; ports 2,3: match=0, raddr=0.
- Write 0xAA to addr 1 and 3; search 0xAA -> match=1, multi=1, raddr=1; search 0x00 with rm=all-ones -> multi=1, raddr=0 of lowest valid entry.
- Ports 0 and 3 write addr 5 with 0x11 and 0x22 same cycle -> search 0x22 hits raddr=5, 0x11 misses; partial wm=0xFFFFFF00, wd=0x33 -> stored 0x33 in low byte, upper bits retained.
- Assert reset mid-run after writes -> all searches match=0 immediately; re_=1 on any port -> that port reads 0 regardless of key.
